mc_inject_arbiter: RTL
======================

Name: mc_inject_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares one multicast source-node input port among N_REQ flit drivers.
- Sits between the per-source drivers (valid/ready/data flit streams) and the router local input port.
- Once a requester wins with a head flit, it owns the port until its tail flit handshakes. Flits of different packets never interleave.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DW, `DW (from params.svh), flit width.
- TYPE_MSB, DW-1, upper bit of the 2-bit flit-type field in bits [TYPE_MSB:TYPE_MSB-1].
- Flit type encoding: 2'b01 head, 2'b00 body, 2'b10 tail, 2'b11 single (head+tail).

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  N_REQ  per-requester flit valid.
- req_ready  output  N_REQ  per-requester flit accept.
- req_data  input  N_REQ*DW  flattened requester flits; requester i uses bits [i*DW +: DW].
- out_valid  output  1  flit valid to router port.
- out_ready  input  1  router accept.
- out_data  output  DW  forwarded flit.
- grant  output  N_REQ  one-hot current owner; all zero in IDLE.
- busy  output  1  high in LOCKED.
- proto_err  output  1  sticky protocol-error flag.

Behaviour:
- Reset values (immediate on rst high, async): state=IDLE, rr_ptr=0, grant=0, busy=0, proto_err=0, out_valid=0, req_ready=0, out_data=0.
- States: IDLE, LOCKED.
- IDLE:
  - Eligible requester i: req_valid[i]=1 and type is head or single.
  - Winner: first eligible index searching rr_ptr, rr_ptr+1, … with wrap modulo N_REQ.
  - If a winner exists: grant<=onehot(winner), state<=LOCKED. No flit transfers in IDLE (1-cycle arbitration bubble).
  - out_valid=0, req_ready=0 throughout IDLE.
- LOCKED (owner g):
  - Combinational pass-through, zero latency: out_valid=req_valid[g], out_data=req_data[g], req_ready[g]=out_ready. All other req_ready bits are 0.
  - A flit is accepted when out_valid & out_ready.
  - Accepted flit of type tail or single: state<=IDLE, grant<=0, rr_ptr<=(g+1) mod N_REQ.
  - Accepted head or body: stay LOCKED.
- out_data is 0 whenever out_valid=0.
- req_valid may drop mid-packet while LOCKED: the port stalls (out_valid=0) and ownership is held. There is no timeout.
- proto_err set (sticky until rst) in either of these cases:
  - In IDLE, a requester presents valid with type body or tail.
  - In LOCKED, the owner's accepted flit is type head.
  - In the LOCKED head case the flit is still forwarded and the state is unchanged.
- A non-eligible requester in IDLE is simply skipped; it never blocks others.
- Simultaneous tail accept and new requests: the new arbitration happens in the following IDLE cycle, so the minimum gap between packets is 1 cycle.
- rst asserted mid-packet: the lock is dropped and the partial packet is abandoned. After reset, arbitration restarts at requester 0.
- Throughput: an L-flit packet takes L+1 cycles with no backpressure.

Optional Feature:
- Macro: MC_INJECT_ARB_CNT_EN.
- Defined:
  - Adds output pkt_cnt, width N_REQ*16: per-requester 16-bit count of completed packets.
  - A requester's count increments on accepted tail or single for that owner, and wraps 0xFFFF->0.
  - All counts reset to 0.
- Undefined: port and counters absent. Arbitration behaviour is identical either way.

Test Plan:
- Single requester 0 sends head,body,body,tail with out_ready=1:
  - grant=0001 at cycle 1, flits out at cycles 1-4, IDLE at cycle 5.
  - rr_ptr=1; pkt_cnt[0]=1 if MC_INJECT_ARB_CNT_EN.
- All 4 requesters hold 2-flit packets (head,tail) from reset:
  - Grant order is 0,1,2,3,0; each packet is contiguous.
  - Each packet takes 3 cycles (1 arbitration + 2 flits).
- Owner 2 mid-packet while requester 1 raises a head:
  - req_ready[1] stays 0 until owner 2's tail is accepted; requester 1 is granted next.
- Backpressure: out_ready low 5 cycles during body flit:
  - out_data held stable, no flit lost or duplicated, ownership held.
- Requester 3 presents body flit in IDLE:
  - proto_err=1 the next cycle and stays 1.
  - Requester 3 is not granted; other requesters are unaffected.
- rst pulsed while LOCKED on requester 1 after 2 of 4 flits:
  - grant=0, busy=0, out_valid=0 immediately.
  - Requester 0's head is granted first after release.

Source files
------------

// File: rtl/mc_inject_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mc_inject_arbiter
//  Description : Packet-atomic round-robin arbiter sharing one multicast
//                source-node router input port among N_REQ flit drivers.
//                A requester that wins with a head (or single) flit owns the
//                port until its tail (or single) flit handshakes, so flits of
//                different packets never interleave. While locked the owner's
//                stream is passed through combinationally (zero latency).
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    N_REQ     number of requesters (2..16)
//    DW        flit width (project-wide `DW, normally from params.svh)
//    TYPE_MSB  upper bit of the 2-bit flit type field [TYPE_MSB:TYPE_MSB-1]
//              01 head, 00 body, 10 tail, 11 single
//  Ports
//    clk        in   clock, all state changes on posedge
//    rst        in   asynchronous active-high reset
//    req_valid  in   [N_REQ]     per-requester flit valid
//    req_ready  out  [N_REQ]     per-requester flit accept
//    req_data   in   [N_REQ*DW]  flattened flits, requester i at [i*DW +: DW]
//    out_valid  out  flit valid to router port
//    out_ready  in   router accept
//    out_data   out  [DW] forwarded flit (zero when out_valid is low)
//    grant      out  [N_REQ] one-hot current owner, zero when idle
//    busy       out  high while a packet owns the port
//    proto_err  out  sticky protocol-error flag
//    pkt_cnt    out  [N_REQ*16] per-requester completed-packet counters,
//                    present only when MC_INJECT_ARB_CNT_EN is defined
//  Build option
//    MC_INJECT_ARB_CNT_EN  adds the pkt_cnt output and its counters
// ============================================================================

`ifndef DW
`define DW 32
`endif

module mc_inject_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DW       = `DW,
    parameter int TYPE_MSB = DW - 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [N_REQ*DW-1:0]   req_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_data,
    output logic [N_REQ-1:0]      grant,
    output logic                  busy,
`ifdef MC_INJECT_ARB_CNT_EN
    output logic [N_REQ*16-1:0]   pkt_cnt,
`endif
    output logic                  proto_err
);

    localparam int PW = $clog2(N_REQ);

    localparam logic [1:0] c_TYPE_HEAD = 2'b01;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_REQ-1:0]  r_grant;
    logic [N_REQ-1:0]  w_grant_nxt;
    logic [PW-1:0]     r_owner;
    logic [PW-1:0]     w_owner_nxt;
    logic [PW-1:0]     r_rr_ptr;
    logic [PW-1:0]     w_rr_ptr_nxt;
    logic              r_proto_err;
    logic              w_proto_err_nxt;

    logic [1:0]        w_type [N_REQ];
    logic [N_REQ-1:0]  w_elig;
    logic [N_REQ-1:0]  w_bad;

    logic              w_win_found;
    logic [PW-1:0]     w_win_idx;
    logic [PW:0]       w_scan;

    logic              w_own_valid;
    logic [1:0]        w_own_type;
    logic [DW-1:0]     w_own_data;
    logic              w_accept;

    // ------------------------------------------------------------------
    // Per-requester flit type decode. Head and single both have bit 0 set,
    // so that bit alone marks a packet start; body and tail in IDLE are
    // protocol violations.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_type
            assign w_type[gi] = req_data[gi*DW + TYPE_MSB -: 2];
            assign w_elig[gi] = req_valid[gi] &  w_type[gi][0];
            assign w_bad[gi]  = req_valid[gi] & ~w_type[gi][0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin search starting at r_rr_ptr with wrap modulo N_REQ.
    // The scan index carries one extra bit so the wrap works for
    // non-power-of-two N_REQ.
    // ------------------------------------------------------------------
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_scan      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_scan = {1'b0, r_rr_ptr} + (PW+1)'(k);
            if (w_scan >= (PW+1)'(N_REQ)) begin
                w_scan = w_scan - (PW+1)'(N_REQ);
            end
            if (!w_win_found && w_elig[w_scan[PW-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_scan[PW-1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Owner selection and zero-latency pass-through.
    // ------------------------------------------------------------------
    always_comb begin
        w_own_valid = 1'b0;
        w_own_type  = 2'b00;
        w_own_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_owner == PW'(i)) begin
                w_own_valid = req_valid[i];
                w_own_type  = w_type[i];
                w_own_data  = req_data[i*DW +: DW];
            end
        end
    end

    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        req_ready = '0;
        if (r_state == ST_LOCKED) begin
            out_valid = w_own_valid;
            out_data  = w_own_valid ? w_own_data : '0;
            req_ready = r_grant & {N_REQ{out_ready}};
        end
    end

    assign w_accept = (r_state == ST_LOCKED) & w_own_valid & out_ready;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_owner_nxt     = r_owner;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_proto_err_nxt = r_proto_err;
        case (r_state)
            ST_IDLE: begin
                if (|w_bad) begin
                    w_proto_err_nxt = 1'b1;
                end
                if (w_win_found) begin
                    w_state_nxt            = ST_LOCKED;
                    w_owner_nxt            = w_win_idx;
                    w_grant_nxt            = '0;
                    w_grant_nxt[w_win_idx] = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (w_accept) begin
                    // Bit 1 set means tail or single: packet ends here.
                    if (w_own_type[1]) begin
                        w_state_nxt  = ST_IDLE;
                        w_grant_nxt  = '0;
                        w_rr_ptr_nxt = (r_owner == PW'(N_REQ-1)) ? '0
                                                                 : r_owner + PW'(1);
                    end else if (w_own_type == c_TYPE_HEAD) begin
                        // A nested head is still forwarded; only flagged.
                        w_proto_err_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_owner     <= w_owner_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_proto_err <= w_proto_err_nxt;
        end
    end

    assign grant     = r_grant;
    assign busy      = (r_state == ST_LOCKED);
    assign proto_err = r_proto_err;

`ifdef MC_INJECT_ARB_CNT_EN
    // Completed-packet counters, free-running 16-bit with natural wrap.
    generate
        for (genvar gc = 0; gc < N_REQ; gc++) begin : g_cnt
            logic [15:0] r_cnt;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= 16'd0;
                end else if (w_accept && w_own_type[1] && r_grant[gc]) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end
            assign pkt_cnt[gc*16 +: 16] = r_cnt;
        end
    endgenerate
`endif

endmodule

`default_nettype wire
